// File: rtl/cell_pos_reader_if.sv
// Bundle of the cell position reader's control, memory-read and output-stream signals.
// master is the reader side; slave is the memory/consumer side.
interface cell_pos_reader_if #(
  parameter int unsigned DATA_WIDTH = 96,
  parameter int unsigned ADDR_WIDTH = 8
);
  logic                  start;
  logic                  busy;
  logic                  done;
  logic [ADDR_WIDTH-1:0] cell_count;
  logic [ADDR_WIDTH-1:0] mem_address;
  logic                  mem_rden;
  logic                  mem_wren;
  logic [DATA_WIDTH-1:0] mem_data;
  logic [DATA_WIDTH-1:0] mem_q;
  logic [DATA_WIDTH-1:0] out_data;
  logic [ADDR_WIDTH-1:0] out_index;
  logic                  out_last;
  logic                  out_valid;
  logic                  out_ready;

  modport master (
    input  start, mem_q, out_ready,
    output busy, done, cell_count, mem_address, mem_rden, mem_wren, mem_data,
           out_data, out_index, out_last, out_valid
  );

  modport slave (
    output start, mem_q, out_ready,
    input  busy, done, cell_count, mem_address, mem_rden, mem_wren, mem_data,
           out_data, out_index, out_last, out_valid
  );
endinterface

// File: rtl/cell_pos_reader.sv
// Streams one cell's particle positions out of its position memory: reads the count at
// address 0, then addresses 1..count through a credit-controlled output FIFO.
module cell_pos_reader #(
  parameter int unsigned DATA_WIDTH   = 96,
  parameter int unsigned PARTICLE_NUM = 220,
  parameter int unsigned ADDR_WIDTH   = 8,
  parameter int unsigned RD_LATENCY   = 2,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input logic               clk,
  input logic               rst,
  cell_pos_reader_if.master bus
);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + RD_LATENCY + 1);
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned LAT_W = $clog2(RD_LATENCY + 1);
  localparam logic [ADDR_WIDTH-1:0] MAX_COUNT = ADDR_WIDTH'(PARTICLE_NUM - 1);

  typedef enum logic [2:0] {StIdle, StRdCnt, StWaitCnt, StStream, StDrain, StFin} state_e;

  state_e                state_q;
  logic [LAT_W-1:0]      wait_q;
  logic [ADDR_WIDTH-1:0] cell_count_q;
  logic [ADDR_WIDTH-1:0] next_addr_q;
  logic [ADDR_WIDTH-1:0] last_addr_q;
  logic [RD_LATENCY-1:0] pipe_v_q;
  logic [ADDR_WIDTH-1:0] pipe_idx_q [RD_LATENCY];
  logic [DATA_WIDTH-1:0] fifo_data_q [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] fifo_idx_q [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] fifo_last_q;
  logic [PTR_W-1:0]      wr_ptr_q;
  logic [PTR_W-1:0]      rd_ptr_q;
  logic [CNT_W-1:0]      occ_q;

  logic [CNT_W-1:0]      inflight;
  logic [ADDR_WIDTH-1:0] raw_count;
  logic [ADDR_WIDTH-1:0] clamped_count;
  logic [ADDR_WIDTH-1:0] push_idx;
  logic                  credit_ok;
  logic                  count_rd;
  logic                  issue;
  logic                  push;
  logic                  pop;
  logic                  drain_done;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LATENCY; i++) begin
      inflight = inflight + CNT_W'(pipe_v_q[i]);
    end
  end

  // Credit check ignores a same-cycle pop so a push can never find the FIFO full.
  assign credit_ok     = (occ_q + inflight) < CNT_W'(FIFO_DEPTH);
  assign count_rd      = (state_q == StRdCnt);
  assign issue         = (state_q == StStream) && credit_ok;
  assign push          = pipe_v_q[RD_LATENCY-1];
  assign push_idx      = pipe_idx_q[RD_LATENCY-1];
  assign pop           = (occ_q != '0) && bus.out_ready;
  assign raw_count     = bus.mem_q[ADDR_WIDTH-1:0];
  assign clamped_count = (raw_count > MAX_COUNT) ? MAX_COUNT : raw_count;
  // Leave DRAIN as the final entry is handed off so done follows the last handshake directly.
  assign drain_done    = (inflight == '0) &&
                         ((occ_q == '0) || ((occ_q == CNT_W'(1)) && pop));

  assign bus.busy        = state_q inside {StRdCnt, StWaitCnt, StStream, StDrain};
  assign bus.done        = (state_q == StFin);
  assign bus.cell_count  = cell_count_q;
  assign bus.mem_rden    = count_rd || issue;
  assign bus.mem_address = count_rd ? '0 : (issue ? next_addr_q : last_addr_q);
  assign bus.mem_wren    = 1'b0;
  assign bus.mem_data    = '0;
  assign bus.out_valid   = (occ_q != '0);
  assign bus.out_data    = fifo_data_q[rd_ptr_q];
  assign bus.out_index   = fifo_idx_q[rd_ptr_q];
  assign bus.out_last    = fifo_last_q[rd_ptr_q];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      wait_q       <= '0;
      cell_count_q <= '0;
      next_addr_q  <= '0;
      last_addr_q  <= '0;
      pipe_v_q     <= '0;
      for (int i = 0; i < RD_LATENCY; i++) pipe_idx_q[i] <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_data_q[i] <= '0;
        fifo_idx_q[i]  <= '0;
      end
      fifo_last_q <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      occ_q       <= '0;
    end else begin
      // Return-path tracker: a slot reaches the end exactly when its mem_q is valid.
      pipe_v_q[0]   <= issue;
      pipe_idx_q[0] <= next_addr_q;
      for (int i = 1; i < RD_LATENCY; i++) begin
        pipe_v_q[i]   <= pipe_v_q[i-1];
        pipe_idx_q[i] <= pipe_idx_q[i-1];
      end

      if (bus.mem_rden) last_addr_q <= bus.mem_address;

      if (push) begin
        fifo_data_q[wr_ptr_q] <= bus.mem_q;
        fifo_idx_q[wr_ptr_q]  <= push_idx;
        fifo_last_q[wr_ptr_q] <= (push_idx == cell_count_q);
        wr_ptr_q              <= ptr_inc(wr_ptr_q);
      end
      if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
      occ_q <= occ_q + CNT_W'(push) - CNT_W'(pop);

      case (state_q)
        StIdle: begin
          if (bus.start) state_q <= StRdCnt;
        end
        StRdCnt: begin
          wait_q  <= '0;
          state_q <= StWaitCnt;
        end
        StWaitCnt: begin
          if (wait_q == LAT_W'(RD_LATENCY - 1)) begin
            cell_count_q <= clamped_count;
            next_addr_q  <= ADDR_WIDTH'(1);
            state_q      <= (clamped_count == '0) ? StFin : StStream;
          end else begin
            wait_q <= wait_q + LAT_W'(1);
          end
        end
        StStream: begin
          if (issue) begin
            if (next_addr_q == cell_count_q) state_q <= StDrain;
            else next_addr_q <= next_addr_q + ADDR_WIDTH'(1);
          end
        end
        StDrain: begin
          if (drain_done) state_q <= StFin;
        end
        StFin: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end
endmodule
